// File: rtl/decode_stage_pkg.sv
// Shared field layout, bundle layout and buffer state encoding for the decode stage.
// Offsets are functions of the register/immediate widths so every instance agrees.
package decode_stage_pkg;

  localparam logic [3:0] RSVD_MSB_DEF = 4'hF;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_MAIN  = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  // Instruction word layout, LSB upwards: imm, rs, rd, dst, src, isfloat, op_msb.
  function automatic int unsigned fld_rs_lsb(input int unsigned imm_w);
    return imm_w;
  endfunction

  function automatic int unsigned fld_rd_lsb(input int unsigned reg_w, input int unsigned imm_w);
    return imm_w + reg_w;
  endfunction

  function automatic int unsigned fld_dst_lsb(input int unsigned reg_w, input int unsigned imm_w);
    return imm_w + 2 * reg_w;
  endfunction

  function automatic int unsigned fld_src_bit(input int unsigned reg_w, input int unsigned imm_w);
    return fld_dst_lsb(reg_w, imm_w) + 2;
  endfunction

  function automatic int unsigned fld_isf_bit(input int unsigned reg_w, input int unsigned imm_w);
    return fld_dst_lsb(reg_w, imm_w) + 3;
  endfunction

  function automatic int unsigned fld_op_lsb(input int unsigned reg_w, input int unsigned imm_w);
    return fld_dst_lsb(reg_w, imm_w) + 4;
  endfunction

  // Decoded bundle layout, LSB upwards: illegal, imm_ext, rs, rd, dst, src, isfloat, opcode[8].
  function automatic int unsigned bnd_imm(input int unsigned word_w);
    return (word_w > 0) ? 1 : 1;
  endfunction

  function automatic int unsigned bnd_rs(input int unsigned word_w);
    return 1 + word_w;
  endfunction

  function automatic int unsigned bnd_rd(input int unsigned reg_w, input int unsigned word_w);
    return 1 + word_w + reg_w;
  endfunction

  function automatic int unsigned bnd_dst(input int unsigned reg_w, input int unsigned word_w);
    return 1 + word_w + 2 * reg_w;
  endfunction

  function automatic int unsigned bnd_src(input int unsigned reg_w, input int unsigned word_w);
    return bnd_dst(reg_w, word_w) + 2;
  endfunction

  function automatic int unsigned bnd_isf(input int unsigned reg_w, input int unsigned word_w);
    return bnd_dst(reg_w, word_w) + 3;
  endfunction

  function automatic int unsigned bnd_opc(input int unsigned reg_w, input int unsigned word_w);
    return bnd_dst(reg_w, word_w) + 4;
  endfunction

  function automatic int unsigned bnd_w(input int unsigned reg_w, input int unsigned word_w);
    return bnd_dst(reg_w, word_w) + 12;
  endfunction

endpackage

// File: rtl/decode_stage_field_decode.sv
// Combinational field decoder: instruction word + extension mode -> packed decoded bundle.
// Kept free of state so a dual-issue front end can instantiate two of them.
module field_decode
  import decode_stage_pkg::*;
#(
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned REG_W    = 4,
  parameter int unsigned IMM_W    = 16,
  parameter logic [3:0]  RSVD_MSB = RSVD_MSB_DEF
) (
  input  logic [WORD_W-1:0]               inst,
  input  logic                            sext_en,
  output logic [bnd_w(REG_W, WORD_W)-1:0] bundle
);

  localparam int unsigned RS_LSB  = fld_rs_lsb(IMM_W);
  localparam int unsigned RD_LSB  = fld_rd_lsb(REG_W, IMM_W);
  localparam int unsigned DST_LSB = fld_dst_lsb(REG_W, IMM_W);
  localparam int unsigned SRC_BIT = fld_src_bit(REG_W, IMM_W);
  localparam int unsigned ISF_BIT = fld_isf_bit(REG_W, IMM_W);
  localparam int unsigned OP_LSB  = fld_op_lsb(REG_W, IMM_W);

  logic [3:0]        op_msb;
  logic [3:0]        op_lsb;
  logic              isfloat;
  logic              src;
  logic [1:0]        dst;
  logic [REG_W-1:0]  rd;
  logic [REG_W-1:0]  rs;
  logic [IMM_W-1:0]  imm;
  logic [WORD_W-1:0] imm_ext;
  logic              illegal;

  assign op_msb  = inst[OP_LSB +: 4];
  assign isfloat = inst[ISF_BIT];
  assign src     = inst[SRC_BIT];
  assign dst     = inst[DST_LSB +: 2];
  assign rd      = inst[RD_LSB +: REG_W];
  assign rs      = inst[RS_LSB +: REG_W];
  assign imm     = inst[IMM_W-1:0];

  // Low opcode nibble comes from rs when the source is a register, else from the immediate top.
  assign op_lsb  = src ? rs[3:0] : imm[IMM_W-1 -: 4];
  assign illegal = (op_msb == RSVD_MSB);

  always_comb begin
    imm_ext = '0;
    if (sext_en) begin
      imm_ext = {{(WORD_W - IMM_W){imm[IMM_W-1]}}, imm};
    end else begin
      imm_ext = {{(WORD_W - IMM_W){1'b0}}, imm};
    end
  end

  assign bundle = {op_msb, op_lsb, isfloat, src, dst, rd, rs, imm_ext, illegal};

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: field decode at the input, sequence tagging, and a
// 2-entry skid buffer (main drives the outputs, skid absorbs one stalled accept).
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned REG_W    = 4,
  parameter int unsigned IMM_W    = 16,
  parameter int unsigned SEQ_W    = 4,
  parameter logic [3:0]  RSVD_MSB = RSVD_MSB_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_inst,
  input  logic              sext_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_opcode,
  output logic [REG_W-1:0]  out_rd,
  output logic [REG_W-1:0]  out_rs,
  output logic              out_isfloat,
  output logic              out_src,
  output logic [1:0]        out_dst,
  output logic [WORD_W-1:0] out_imm,
  output logic              out_illegal,
  output logic [SEQ_W-1:0]  out_seq
);

  localparam int unsigned BW    = bnd_w(REG_W, WORD_W);
  localparam int unsigned EW    = BW + SEQ_W;
  localparam int unsigned O_ILL = SEQ_W;
  localparam int unsigned O_IMM = SEQ_W + bnd_imm(WORD_W);
  localparam int unsigned O_RS  = SEQ_W + bnd_rs(WORD_W);
  localparam int unsigned O_RD  = SEQ_W + bnd_rd(REG_W, WORD_W);
  localparam int unsigned O_DST = SEQ_W + bnd_dst(REG_W, WORD_W);
  localparam int unsigned O_SRC = SEQ_W + bnd_src(REG_W, WORD_W);
  localparam int unsigned O_ISF = SEQ_W + bnd_isf(REG_W, WORD_W);
  localparam int unsigned O_OPC = SEQ_W + bnd_opc(REG_W, WORD_W);

  logic [BW-1:0]    dec;
  logic [EW-1:0]    new_entry;
  logic [EW-1:0]    main_q, main_d;
  logic [EW-1:0]    skid_q, skid_d;
  buf_state_e       state_q, state_d;
  logic [SEQ_W-1:0] seq_q;
  logic             in_ready_q;
  logic             accept;
  logic             pop;

  field_decode #(
    .WORD_W   (WORD_W),
    .REG_W    (REG_W),
    .IMM_W    (IMM_W),
    .RSVD_MSB (RSVD_MSB)
  ) u_field_decode (
    .inst    (in_inst),
    .sext_en (sext_en),
    .bundle  (dec)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != BUF_EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;
  assign new_entry = {dec, seq_q};

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (accept) begin
            main_d  = new_entry;
            state_d = BUF_MAIN;
          end
        end
        BUF_MAIN: begin
          if (pop && accept) begin
            main_d = new_entry;
          end else if (pop) begin
            state_d = BUF_EMPTY;
          end else if (accept) begin
            skid_d  = new_entry;
            state_d = BUF_FULL;
          end
        end
        BUF_FULL: begin
          // in_ready is low here, so the only event is a pop promoting skid to main.
          if (pop) begin
            main_d  = skid_q;
            state_d = BUF_MAIN;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BUF_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      seq_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != BUF_FULL);
      // Accepts during flush still consume a tag, keeping tags tied to fetch order.
      if (accept) begin
        seq_q <= seq_q + SEQ_W'(1);
      end
    end
  end

  assign out_seq     = main_q[SEQ_W-1:0];
  assign out_illegal = main_q[O_ILL];
  assign out_imm     = main_q[O_IMM +: WORD_W];
  assign out_rs      = main_q[O_RS +: REG_W];
  assign out_rd      = main_q[O_RD +: REG_W];
  assign out_dst     = main_q[O_DST +: 2];
  assign out_src     = main_q[O_SRC];
  assign out_isfloat = main_q[O_ISF];
  assign out_opcode  = main_q[O_OPC +: 8];

endmodule
